mem_arbiter: RTL and testbench

Two-master arbiter sharing one data-memory port (daddr/drdata/dwdata/dwe style, byte write enables) between the cpu data port (master 0) and a second bus master such as a DMA or debug loader (master 1). Sits between the cpu and the data memory. Issues at most one memory access per cycle using a req/gnt handshake. Returns read data one cycle later, tagged back to the issuing master.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 19 +
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-master data-memory arbiter.
package arb_pkg;
   localparam int NUM_MASTERS = 2;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   typedef enum logic {
      LAST0 = 1'b0,
      LAST1 = 1'b1
   } state_t;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; one-hot grant.
import arb_pkg::*;

module rr_pick2 (
   input  logic [NUM_MASTERS-1:0] req,
   input  state_t                 last,
   output logic [NUM_MASTERS-1:0] gnt
);
   always_comb begin
      gnt = '0;
      unique case (req)
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         // contention: favour whoever did not win last
         2'b11: gnt = (last == LAST1) ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates cpu data port (m0) and a second master (m1)
// onto one memory port; read data is tagged back to its issuer.
import arb_pkg::*;

module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [DW/8-1:0] m0_we,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [DW/8-1:0] m1_we,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [DW/8-1:0] mem_we,
   input  logic [DW-1:0] mem_rdata
);
   state_t state_q, state_d;
   logic   pend_q, pend_d;
   owner_t owner_q, owner_d;

   logic [NUM_MASTERS-1:0] pick;
   logic [NUM_MASTERS-1:0] gnt;
   logic                   rd_issue;

   rr_pick2 u_pick (
      .req  ({m1_req, m0_req}),
      .last (state_q),
      .gnt  (pick)
   );

   // no grant may reach memory while reset is held
   assign gnt    = pick & {NUM_MASTERS{reset}};
   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = '0;
      unique case (1'b1)
         gnt[0]: begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
         end
         gnt[1]: begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
         end
         default: ;
      endcase
   end

   assign rd_issue = (|gnt) && (mem_we == '0);

   always_comb begin
      state_d = state_q;
      pend_d  = rd_issue;
      owner_d = owner_q;
      unique case (1'b1)
         gnt[0]: state_d = LAST0;
         gnt[1]: state_d = LAST1;
         default: ;
      endcase
      if (rd_issue) begin
         owner_d = gnt[1] ? OWN_M1 : OWN_M0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LAST1;
         pend_q  <= 1'b0;
         owner_q <= OWN_M0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
      end
   end

   assign m0_rvalid = pend_q && (owner_q == OWN_M0);
   assign m1_rvalid = pend_q && (owner_q == OWN_M1);
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-return scoreboard.
import arb_pkg::*;

module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 0, m1_req = 0;
   logic [31:0] m0_addr = 0, m1_addr = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0;
   logic [3:0]  m0_we = 0, m1_we = 0;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m1_req(m1_req), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [16];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'h1111_2222;
      mem[1] = 32'h3333_4444;
      mem[4] = 32'hDEAD_BEEF;
      mem[8] = 32'hAAAA_BBBB;
   end

   // registered memory, 1-cycle read latency
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[5:2]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   typedef struct {
      logic        own;
      logic [31:0] data;
      int          cyc;
   } rd_t;
   rd_t q[$];

   // monitor: pops an expected return whenever a master sees rvalid
   initial forever begin
      @(negedge clk);
      #1;
      if (m0_rvalid || m1_rvalid) begin
         if (q.size() == 0) begin
            chk("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 0);
         end else begin
            rd_t e;
            e = q.pop_front();
            chk("rv_owner", {m1_rvalid, m0_rvalid},
                e.own ? 32'd2 : 32'd1);
            chk("rdata", e.own ? m1_rdata : m0_rdata, e.data);
            chk("other_rdata", e.own ? m0_rdata : m1_rdata, 0);
            chk("rv_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step(
      input logic r0, input logic [31:0] a0, w0, input logic [3:0] we0,
      input logic r1, input logic [31:0] a1, w1, input logic [3:0] we1,
      input logic [1:0] eg, input logic [31:0] erd);
      logic [31:0] ea, ew;
      logic [3:0]  ewe;
      m0_req = r0; m0_addr = a0; m0_wdata = w0; m0_we = we0;
      m1_req = r1; m1_addr = a1; m1_wdata = w1; m1_we = we1;
      #1;
      ea  = eg[0] ? a0 : eg[1] ? a1 : 32'h0;
      ew  = eg[0] ? w0 : eg[1] ? w1 : 32'h0;
      ewe = eg[0] ? we0 : eg[1] ? we1 : 4'h0;
      chk("m0_gnt", m0_gnt, eg[0]);
      chk("m1_gnt", m1_gnt, eg[1]);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ew);
      chk("mem_we", mem_we, ewe);
      if (eg != 2'b00 && ewe == 4'h0)
         q.push_back('{own: eg[1], data: erd, cyc: cyc + 1});
      @(negedge clk);
   endtask

   initial begin
      // reset held with both masters requesting
      m0_req = 1; m1_req = 1; m1_addr = 32'h4;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
      reset = 1;
      // contention: m0, m1, m0, m1
      step(1, 32'h00, 0, 0, 1, 32'h04, 0, 0, 2'b01, 32'h1111_2222);
      step(1, 32'h10, 0, 0, 1, 32'h04, 0, 0, 2'b10, 32'h3333_4444);
      step(1, 32'h10, 0, 0, 1, 32'h20, 0, 0, 2'b01, 32'hDEAD_BEEF);
      step(1, 32'h00, 0, 0, 1, 32'h20, 0, 0, 2'b10, 32'hAAAA_BBBB);
      // idle
      step(0, 32'h44, 1, 4'hF, 0, 32'h48, 2, 4'hF, 2'b00, 0);
      // single master read
      step(0, 0, 0, 0, 1, 32'h10, 0, 0, 2'b10, 32'hDEAD_BEEF);
      // partial write, then read back merged word
      step(1, 32'h20, 32'h1234_5678, 4'b0011, 0, 0, 0, 0,
           2'b01, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, 1, 32'h20, 0, 0, 2'b10, 32'hAAAA_5678);
      // back-to-back reads from different masters
      step(1, 32'h00, 0, 0, 0, 0, 0, 0, 2'b01, 32'h1111_2222);
      step(0, 0, 0, 0, 1, 32'h04, 0, 0, 2'b10, 32'h3333_4444);
      // write then immediate read of the same word
      step(1, 32'h08, 32'hCAFE_F00D, 4'hF, 1, 32'h08, 0, 0,
           2'b01, 0);
      step(0, 0, 0, 0, 1, 32'h08, 0, 0, 2'b10, 32'hCAFE_F00D);
      // reset just after a read grant drops the return
      m0_req = 1; m0_addr = 32'h10; m0_we = 0; m1_req = 0;
      #1;
      chk("mid_m0_gnt", m0_gnt, 1);
      @(posedge clk);
      #1;
      reset = 0;
      m0_req = 0;
      @(negedge clk);
      #2;
      chk("mid_rvalid", {m1_rvalid, m0_rvalid}, 0);
      chk("mid_pending", 32'(dut.pend_q), 0);
      chk("mid_state", 32'(dut.state_q), 32'(LAST1));
      @(negedge clk);
      reset = 1;
      step(1, 32'h00, 0, 0, 1, 32'h04, 0, 0, 2'b01, 32'h1111_2222);
      step(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      repeat (3) @(negedge clk);
      chk("sb_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
